mem_stage: RTL
==============

// Module: mem_stage
// PURPOSE
//  Memory-access pipeline stage between the execute stage and the writeback stage.
//  Latches the execute-stage result bus on the valid/allow_in handshake.
//  For loads, waits RD_LAT cycles for data_sram_rdata and holds the returned word until writeback accepts it.
//  Selects the final writeback value and publishes {rf_we,dest} to the hazard checker.
// PARAMETERS
//  RD_LAT   1   cycles from the address cycle (last EXE cycle) to data_sram_rdata valid; legal 1..7
// PORTS
//  clk              in   1   clock, all state on posedge
//  rst              in   1   asynchronous active-high reset
//  es_to_ms_valid   in   1   execute stage offers an instruction
//  es_to_ms_bus     in   71  {rf_or_mem[70], rf_we[69], dest[68:64], pc[63:32], alu_result[31:0]}
//  ms_allow_in      out  1   stage can accept an instruction this cycle
//  data_sram_rdata  in   32  data SRAM read word, valid RD_LAT cycles after address
//  ws_allow_in      in   1   writeback stage can accept
//  ms_to_ws_valid   out  1   instruction offered to writeback
//  ms_to_ws_bus     out  70  {rf_we[69], dest[68:64], pc[63:32], final_result[31:0]}
//  ms_to_che_bus    out  7   {ms_valid[6], rf_we[5], dest[4:0]} for hazard detection
// BEHAVIOUR
//  Reset (async, any cycle): ms_valid=0, bus reg=0, lat_cnt=0, rdata_hold=0, hold_vld=0.
//   Outputs after reset: ms_allow_in=1, ms_to_ws_valid=0, ms_to_ws_bus=0, ms_to_che_bus=0.
//  Handshake:
//   ms_allow_in    = !ms_valid || (ms_ready_go && ws_allow_in)
//   ms_to_ws_valid = ms_valid && ms_ready_go
//   On posedge with ms_allow_in: ms_valid <= es_to_ms_valid.
//   On posedge with ms_allow_in && es_to_ms_valid: bus reg <= es_to_ms_bus, lat_cnt <= RD_LAT-1, hold_vld <= 0.
//  Load wait (rf_or_mem=1):
//   rd_now = ms_valid && rf_or_mem && lat_cnt==0 && !hold_vld.
//   Each cycle with ms_valid && lat_cnt!=0: lat_cnt decrements by 1.
//   rd_now cycle: rdata_hold <= data_sram_rdata and hold_vld <= 1, unless the instruction leaves this same cycle.
//   ms_ready_go = !rf_or_mem || lat_cnt==0. Rdata is usable in the rd_now cycle, and after it via the hold register.
//   RD_LAT=1: load enters with lat_cnt=0 and is ready in its first MEM cycle.
//  Result: final_result = !rf_or_mem ? alu_result : (hold_vld ? rdata_hold : data_sram_rdata).
//   Word loads only; no byte or half-word extraction.
//  Back-pressure: if ws_allow_in=0 after rdata has arrived, the held word is used.
//   A changing data_sram_rdata must not alter ms_to_ws_bus while the instruction is held.
//  Simultaneous events: leaving and entering in the same edge is legal.
//   The new instruction's lat_cnt and hold_vld load; the outgoing capture is discarded.
//  Non-load (rf_or_mem=0): ready in the first cycle, zero added latency; a store is treated like an ALU op.
//  Hazard bus: ms_to_che_bus = {ms_valid, rf_we && ms_valid, dest}. It is live during load wait cycles.
//  Reset mid-load: the instruction is dropped and no ms_to_ws_valid is emitted for it.
// TESTING
//  T1 ALU op: bus pc=0x1c000000, alu_result=0x12345678, rf_we=1, dest=5, ws_allow_in=1.
//   -> ms_to_ws_valid next cycle with final_result=0x12345678 and dest=5; ms_allow_in stays 1.
//  T2 load, RD_LAT=1: rf_or_mem=1, rdata=0xDEADBEEF in the first MEM cycle.
//   -> same cycle ms_to_ws_valid=1, final_result=0xDEADBEEF.
//  T3 load, RD_LAT=3: ms_to_ws_valid=0 for 2 cycles, ms_allow_in=0, che_bus={1,1,dest}.
//   -> cycle 3 result equals the rdata of that cycle.
//  T4 load with ws_allow_in=0 for 4 cycles after rdata 0xCAFEF00D; rdata then changes to 0x0.
//   -> ms_to_ws_bus holds 0xCAFEF00D and is accepted on the release cycle.
//  T5 back-to-back: load, ALU op, load with ws_allow_in=1 and RD_LAT=1.
//   -> three consecutive writeback transfers, in order, with correct pcs.
//  T6 rst asserted asynchronously mid-wait (RD_LAT=3, cycle 2).
//   -> outputs zero immediately; ms_allow_in=1; no stale transfer after release.

Source files
------------

// File: rtl/mem_stage.sv
// Memory-access stage: latches the execute bus, waits out the SRAM read
// latency for loads, and offers the final result to writeback.
module mem_stage #(
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        es_to_ms_valid,
  input  logic [70:0] es_to_ms_bus,
  output logic        ms_allow_in,
  input  logic [31:0] data_sram_rdata,
  input  logic        ws_allow_in,
  output logic        ms_to_ws_valid,
  output logic [69:0] ms_to_ws_bus,
  output logic [6:0]  ms_to_che_bus
);

  typedef struct packed {
    logic        rf_or_mem;
    logic        rf_we;
    logic [4:0]  dest;
    logic [31:0] pc;
    logic [31:0] alu_result;
  } es_bus_t;

  localparam logic [2:0] LAT_INIT = 3'(RD_LAT - 1);

  es_bus_t     bus_r;
  logic        ms_valid;
  logic [2:0]  lat_cnt;
  logic [31:0] rdata_hold;
  logic        hold_vld;

  logic        ms_ready_go;
  logic        accept;
  logic        leave;
  logic        rd_now;
  logic [31:0] final_result;

  assign ms_ready_go = !bus_r.rf_or_mem || (lat_cnt == 3'd0);
  assign ms_allow_in = !ms_valid || (ms_ready_go && ws_allow_in);
  assign ms_to_ws_valid = ms_valid && ms_ready_go;

  assign accept = ms_allow_in && es_to_ms_valid;
  assign leave  = ms_to_ws_valid && ws_allow_in;

  assign rd_now = ms_valid && bus_r.rf_or_mem
               && (lat_cnt == 3'd0) && !hold_vld;

  // The held copy wins once captured, so SRAM bus changes stay invisible.
  always_comb begin
    final_result = bus_r.alu_result;
    if (bus_r.rf_or_mem) begin
      final_result = hold_vld ? rdata_hold : data_sram_rdata;
    end
  end

  assign ms_to_ws_bus = {bus_r.rf_we, bus_r.dest,
                         bus_r.pc, final_result};

  assign ms_to_che_bus = {ms_valid,
                          bus_r.rf_we && ms_valid,
                          bus_r.dest};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ms_valid <= 1'b0;
    end else if (ms_allow_in) begin
      ms_valid <= es_to_ms_valid;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_r      <= '0;
      lat_cnt    <= 3'd0;
      rdata_hold <= 32'd0;
      hold_vld   <= 1'b0;
    end else if (accept) begin
      bus_r    <= es_to_ms_bus;
      lat_cnt  <= LAT_INIT;
      hold_vld <= 1'b0;
    end else begin
      if (ms_valid && lat_cnt != 3'd0) begin
        lat_cnt <= lat_cnt - 3'd1;
      end
      if (leave) begin
        hold_vld <= 1'b0;
      end else if (rd_now) begin
        rdata_hold <= data_sram_rdata;
        hold_vld   <= 1'b1;
      end
    end
  end

endmodule
